// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transfer sequencer.
// Holds the FSM encoding and default widths.
package spi_seq_pkg;

  localparam int DW_DEF    = 8;
  localparam int CNT_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_xfer_cnt.sv
// Transfer counter with sticky interrupt and overrun flags.
// Set beats spif_clr when both land in the same cycle.
module spi_xfer_cnt
  import spi_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             drop,
  input  logic             clr,
  input  logic             spif_clr,
  input  logic [CNT_W-1:0] icnt,
  output logic             spif,
  output logic             ovr
);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = tick && (cnt == icnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      spif <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (tick)
        cnt <= hit ? '0 : cnt + 1'b1;

      if (hit)
        spif <= 1'b1;
      else if (spif_clr)
        spif <= 1'b0;

      if (drop)
        ovr <= 1'b1;
      else if (spif_clr)
        ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer: write FIFO -> shift engine -> read FIFO.
// One byte in flight; clr during a transfer lets the engine finish, then drops it.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] icnt,
  input  logic             wf_empty,
  input  logic [DW-1:0]    wf_dout,
  output logic             wf_re,
  output logic             eng_start,
  output logic [DW-1:0]    eng_tx,
  input  logic             eng_done,
  input  logic [DW-1:0]    eng_rx,
  input  logic             rf_full,
  output logic             rf_we,
  output logic [DW-1:0]    rf_din,
  input  logic             spif_clr,
  output logic             spif,
  output logic             ovr,
  output logic             busy
);

  state_t          state, state_n;
  logic [DW-1:0]   tx_q, rx_q;
  logic            abort_q;
  logic            pop;
  logic            store;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !wf_empty && !clr) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (eng_done)
          state_n = (abort_q || clr) ? IDLE : STORE;
      end
      STORE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_n;
      if (pop)
        tx_q <= wf_dout;
      if (state == WAIT && eng_done)
        rx_q <= eng_rx;
      // abort marker lives only until the FSM is back in IDLE
      if (state_n == IDLE)
        abort_q <= 1'b0;
      else if (clr && (state == START || state == WAIT))
        abort_q <= 1'b1;
    end
  end

  assign store     = (state == STORE);
  assign wf_re     = pop;
  assign eng_start = (state == START);
  assign eng_tx    = tx_q;
  assign rf_we     = store && !rf_full;
  assign rf_din    = rx_q;
  assign busy      = (state != IDLE);

  spi_xfer_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (store),
    .drop     (store && rf_full),
    .clr      (clr),
    .spif_clr (spif_clr),
    .icnt     (icnt),
    .spif     (spif),
    .ovr      (ovr)
  );

endmodule
